// File: rtl/sr_pulse_driver.sv
// Debounced push-button front end driving fixed-width active-low set/reset pulses into an SR latch.
// Optional post-pulse holdoff gap enabled by defining SR_PULSE_DRIVER_HOLDOFF_EN.
module sr_pulse_driver #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned PULSE_CYCLES    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_set,
  input  logic btn_reset,
  output logic set_n,
  output logic reset_n,
  output logic busy,
  output logic conflict
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PwW = $clog2(PULSE_CYCLES + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PwW-1:0] PwLast = PwW'(PULSE_CYCLES - 1);

`ifdef SR_PULSE_DRIVER_HOLDOFF_EN
  typedef enum logic [1:0] {StIdle, StSetPulse, StResetPulse, StHoldoff} state_e;
`else
  typedef enum logic [1:0] {StIdle, StSetPulse, StResetPulse} state_e;
`endif

  // Channel index 0 is set, 1 is reset.
  logic [1:0]     sync1_q, sync2_q;
  logic [1:0]     level_q, level_d, level_prev_q;
  logic [DbW-1:0] db_cnt_q [2];
  logic [DbW-1:0] db_cnt_d [2];

  state_e         state_q, state_d;
  logic [PwW-1:0] pulse_cnt_q, pulse_cnt_d;
  logic           conflict_d, set_n_d, reset_n_d;
  logic           ev_set, ev_reset;

  // A level toggles once the synchronised input has disagreed with it for DEBOUNCE_CYCLES samples.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      level_d[i]  = level_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          level_d[i] = ~level_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  assign ev_set   = level_q[0] & ~level_prev_q[0];
  assign ev_reset = level_q[1] & ~level_prev_q[1];

  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    conflict_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        pulse_cnt_d = '0;
        if (ev_set && ev_reset) begin
          conflict_d = 1'b1;
        end else if (ev_set) begin
          state_d = StSetPulse;
        end else if (ev_reset) begin
          state_d = StResetPulse;
        end
      end
      StSetPulse, StResetPulse: begin
        if (pulse_cnt_q == PwLast) begin
          pulse_cnt_d = '0;
`ifdef SR_PULSE_DRIVER_HOLDOFF_EN
          state_d     = StHoldoff;
`else
          state_d     = StIdle;
`endif
        end else begin
          pulse_cnt_d = pulse_cnt_q + PwW'(1);
        end
      end
`ifdef SR_PULSE_DRIVER_HOLDOFF_EN
      StHoldoff: begin
        if (pulse_cnt_q == PwLast) begin
          pulse_cnt_d = '0;
          state_d     = StIdle;
        end else begin
          pulse_cnt_d = pulse_cnt_q + PwW'(1);
        end
      end
`endif
      default: begin
        state_d     = StIdle;
        pulse_cnt_d = '0;
      end
    endcase
    // Outputs follow the next state so the pulse edge coincides with the state change.
    set_n_d   = (state_d != StSetPulse);
    reset_n_d = (state_d != StResetPulse);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      db_cnt_q[0]  <= '0;
      db_cnt_q[1]  <= '0;
      state_q      <= StIdle;
      pulse_cnt_q  <= '0;
      conflict     <= 1'b0;
      set_n        <= 1'b1;
      reset_n      <= 1'b1;
    end else begin
      sync1_q      <= {btn_reset, btn_set};
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      db_cnt_q[0]  <= db_cnt_d[0];
      db_cnt_q[1]  <= db_cnt_d[1];
      state_q      <= state_d;
      pulse_cnt_q  <= pulse_cnt_d;
      conflict     <= conflict_d;
      set_n        <= set_n_d;
      reset_n      <= reset_n_d;
    end
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Randomised bench for sr_pulse_driver against a window-based behavioural model.
module tb_sr_pulse_driver;

  localparam int unsigned D = 4;
  localparam int unsigned P = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_set = 1'b0;
  logic btn_reset = 1'b0;
  logic set_n, reset_n, busy, conflict;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  // Model state.
  logic [1:0] m_sync1, m_sync2, m_lvl, m_prev;
  logic [1:0] hist [D];
  int         m_start, m_free, m_kind;
  logic       m_conflict;

  int len, mode;

  sr_pulse_driver #(
    .DEBOUNCE_CYCLES(D),
    .PULSE_CYCLES   (P)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_set  (btn_set),
    .btn_reset(btn_reset),
    .set_n    (set_n),
    .reset_n  (reset_n),
    .busy     (busy),
    .conflict (conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0b want=%0b", tag, cyc, obs, exp);
    end
  endtask

  // Level flips when the last D synchronised samples all disagree with it.
  task automatic model_edge();
    logic [1:0] new_lvl;
    logic       ev_s, ev_r, idle, all_diff;
    if (!rst_n) begin
      m_sync1 = '0;
      m_sync2 = '0;
      m_lvl = '0;
      m_prev = '0;
      for (int i = 0; i < int'(D); i++) hist[i] = '0;
      m_start = -1000;
      m_free = -1000;
      m_kind = 0;
      m_conflict = 1'b0;
    end else begin
      ev_s = m_lvl[0] & ~m_prev[0];
      ev_r = m_lvl[1] & ~m_prev[1];
      idle = cyc > m_free;
      m_conflict = idle && ev_s && ev_r;
      if (idle && (ev_s ^ ev_r)) begin
        m_start = cyc;
        m_kind = ev_s ? 0 : 1;
`ifdef SR_PULSE_DRIVER_HOLDOFF_EN
        m_free = cyc + 2 * int'(P);
`else
        m_free = cyc + int'(P);
`endif
      end
      for (int i = 0; i < int'(D) - 1; i++) hist[i] = hist[i+1];
      hist[D-1] = m_sync2;
      new_lvl = m_lvl;
      for (int ch = 0; ch < 2; ch++) begin
        all_diff = 1'b1;
        for (int i = 0; i < int'(D); i++) if (hist[i][ch] == m_lvl[ch]) all_diff = 1'b0;
        if (all_diff) new_lvl[ch] = ~m_lvl[ch];
      end
      m_prev = m_lvl;
      m_lvl = new_lvl;
      m_sync2 = m_sync1;
      m_sync1 = {btn_reset, btn_set};
    end
  endtask

  task automatic step();
    logic in_pulse;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    in_pulse = (cyc >= m_start) && (cyc < m_start + int'(P));
    check("set_n", set_n, !(in_pulse && m_kind == 0));
    check("reset_n", reset_n, !(in_pulse && m_kind == 1));
    check("busy", busy, (cyc >= m_start) && (cyc < m_free));
    check("conflict", conflict, m_conflict);
    check("no_overlap", set_n | reset_n, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    repeat (3) step();
    rst_n = 1'b1;
    step();  // edge 0
    step();  // edge 1
    btn_set = 1'b1;
    for (int n = 2; n <= 12; n++) begin
      step();
      check("clean_set_n", set_n, !(n >= 8 && n <= 10));
      check("clean_reset_n", reset_n, 1'b1);
    end
    btn_set = 1'b0;

    for (int seg = 0; seg < 300; seg++) begin
      len = $urandom_range(1, 24);
      mode = $urandom_range(0, 3);
      for (int c = 0; c < len; c++) begin
        rst_n = ($urandom_range(0, 149) != 0);
        case (mode)
          0: if (c == 0) {btn_reset, btn_set} = 2'($urandom_range(0, 3));
          1: if (c % 2 == 0) btn_set = ~btn_set;
          2: if (c % 2 == 0) btn_reset = ~btn_reset;
          default: if (c == 0) begin
            btn_set = $urandom_range(0, 1) != 0;
            btn_reset = btn_set;
          end
        endcase
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
